// File: rtl/fetch_control_unit.sv
// Fetch-stage sequencer: PC/IF-ID write enables, flush and redirect selects, halt and debug single-step.
// Define FETCH_PERF_CNT_EN to build the saturating stall/flush performance counters; otherwise they read 0.
module fetch_control_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inMemReadEx,
  input  logic [4:0]       inRtEx,
  input  logic [4:0]       inRsId,
  input  logic [4:0]       inRtId,
  input  logic             inBranchTaken,
  input  logic             inJumpId,
  input  logic             inHaltId,
  input  logic             inRunMode,
  input  logic             inStepReq,
  output logic             outPCWrite,
  output logic             outIF_IDWrite,
  output logic             outIF_Flush,
  output logic             outPCSrc,
  output logic             outJump,
  output logic             outEnable,
  output logic             outHalted,
  output logic [CNT_W-1:0] outStallCnt,
  output logic [CNT_W-1:0] outFlushCnt
);

  typedef enum logic [1:0] {RUN, FLUSH, STEP_WAIT, HALT} stateT;

  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

  stateT      state, nextState;
  logic [2:0] flushLeft, nextFlushLeft;
  logic       firstCycle;
  logic       stepReqQ;
  logic       hazard;
  logic       stepEdge;
  logic       waitForStep;
  stateT      modeState;

  assign hazard   = inMemReadEx && (inRtEx != 5'd0) &&
                    ((inRtEx == inRsId) || (inRtEx == inRtId));
  assign stepEdge = inStepReq && !stepReqQ;
  // Leaving reset with single-step selected must not execute a free cycle first.
  assign waitForStep = (state == STEP_WAIT) || ((state == RUN) && firstCycle && !inRunMode);
  assign modeState   = inRunMode ? RUN : STEP_WAIT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      flushLeft  <= 3'd0;
      firstCycle <= 1'b1;
      stepReqQ   <= 1'b0;
    end else begin
      state      <= nextState;
      flushLeft  <= nextFlushLeft;
      firstCycle <= 1'b0;
      stepReqQ   <= inStepReq;
    end
  end

  always_comb begin
    nextState     = state;
    nextFlushLeft = flushLeft;
    outPCWrite    = 1'b0;
    outIF_IDWrite = 1'b0;
    outIF_Flush   = 1'b0;
    outPCSrc      = 1'b0;
    outJump       = 1'b0;
    outEnable     = 1'b0;
    outHalted     = 1'b0;
    case (state)
      RUN, STEP_WAIT: begin
        if (waitForStep && !stepEdge) begin
          nextState = modeState;
        end else if (inHaltId) begin
          nextState = HALT;
        end else if (hazard) begin
          outEnable = 1'b1;
          nextState = modeState;
        end else if (inBranchTaken || inJumpId) begin
          // The redirect cycle itself is the first flush cycle; extra bubbles go through FLUSH.
          outPCWrite  = 1'b1;
          outIF_Flush = 1'b1;
          outEnable   = 1'b1;
          outJump     = inJumpId;
          outPCSrc    = inBranchTaken && !inJumpId;
          if (MULTI_FLUSH) begin
            nextState     = FLUSH;
            nextFlushLeft = FLUSH_LOAD;
          end else begin
            nextState = modeState;
          end
        end else begin
          outPCWrite    = 1'b1;
          outIF_IDWrite = 1'b1;
          outEnable     = 1'b1;
          nextState     = modeState;
        end
      end
      FLUSH: begin
        outPCWrite    = 1'b1;
        outIF_Flush   = 1'b1;
        outEnable     = 1'b1;
        nextFlushLeft = flushLeft - 3'd1;
        if (flushLeft <= 3'd1) begin
          nextState = modeState;
        end
      end
      HALT: begin
        outHalted = 1'b1;
      end
      default: begin
        nextState = RUN;
      end
    endcase
    if (!reset) begin
      outPCWrite    = 1'b0;
      outIF_IDWrite = 1'b0;
      outIF_Flush   = 1'b1;
      outPCSrc      = 1'b0;
      outJump       = 1'b0;
      outEnable     = 1'b0;
      outHalted     = 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt, flushCnt;
  logic             stallInc, flushInc;

  // A load-use stall is the only case that keeps the latch enabled while freezing the PC.
  assign stallInc = reset && outEnable && !outPCWrite;
  assign flushInc = reset && outIF_Flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallInc && !(&stallCnt)) stallCnt <= stallCnt + 1'b1;
      if (flushInc && !(&flushCnt)) flushCnt <= flushCnt + 1'b1;
    end
  end

  assign outStallCnt = stallCnt;
  assign outFlushCnt = flushCnt;
`else
  assign outStallCnt = '0;
  assign outFlushCnt = '0;
`endif

endmodule

// File: tb/tb_fetch_control_unit.sv
// Self-checking bench for fetch_control_unit: vector table, directed step/halt/reset sequences,
// and randomized traffic against a behavioural reference model.
module tb_fetch_control_unit;

  localparam int FC      = 3;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          inMemReadEx = 1'b0;
  logic [4:0]    inRtEx = '0, inRsId = '0, inRtId = '0;
  logic          inBranchTaken = 1'b0, inJumpId = 1'b0, inHaltId = 1'b0;
  logic          inRunMode = 1'b1, inStepReq = 1'b0;
  logic          outPCWrite, outIF_IDWrite, outIF_Flush, outPCSrc, outJump, outEnable, outHalted;
  logic [CW-1:0] outStallCnt, outFlushCnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: halted latch, remaining bubble cycles, step-wait, step edge history.
  bit mHalted, mWaiting, mFirst, mPrevReq;
  int mFlushLeft, mStall, mFlush;

  typedef struct {
    logic       memRead;
    logic [4:0] rtEx, rsId, rtId;
    logic       branch, jump, halt, runMode, stepReq;
    logic [6:0] exp;
  } vecT;

  vecT vecs [12];

  fetch_control_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .inMemReadEx(inMemReadEx), .inRtEx(inRtEx), .inRsId(inRsId), .inRtId(inRtId),
    .inBranchTaken(inBranchTaken), .inJumpId(inJumpId), .inHaltId(inHaltId),
    .inRunMode(inRunMode), .inStepReq(inStepReq),
    .outPCWrite(outPCWrite), .outIF_IDWrite(outIF_IDWrite), .outIF_Flush(outIF_Flush),
    .outPCSrc(outPCSrc), .outJump(outJump), .outEnable(outEnable), .outHalted(outHalted),
    .outStallCnt(outStallCnt), .outFlushCnt(outFlushCnt)
  );

  always #5 clk = ~clk;

  function automatic vecT mkVec(input logic mr, input int rtE, input int rsI, input int rtI,
                                input logic br, input logic jp, input logic ht, input logic [6:0] e);
    vecT v;
    v.memRead = mr; v.rtEx = 5'(rtE); v.rsId = 5'(rsI); v.rtId = 5'(rtI);
    v.branch = br; v.jump = jp; v.halt = ht; v.runMode = 1'b1; v.stepReq = 1'b0; v.exp = e;
    return v;
  endfunction

  task automatic compare(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic mr, input logic [4:0] rtE, input logic [4:0] rsI,
                               input logic [4:0] rtI, input logic br, input logic jp,
                               input logic ht, input logic rm, input logic sr);
    @(negedge clk);
    inMemReadEx = mr; inRtEx = rtE; inRsId = rsI; inRtId = rtI;
    inBranchTaken = br; inJumpId = jp; inHaltId = ht; inRunMode = rm; inStepReq = sr;
    #1;
  endtask

  // Control bits packed as {PCWrite, IF_IDWrite, Flush, PCSrc, Jump, Enable, Halted}.
  task automatic modelEval(output logic [6:0] ctl, output bit stallEv, output bit goHalt,
                           output bit redirect);
    bit gated, granted, haz;
    ctl = '0; stallEv = 0; goHalt = 0; redirect = 0;
    if (!reset) ctl = 7'b0010000;
    else if (mHalted) ctl = 7'b0000001;
    else if (mFlushLeft > 0) ctl = 7'b1010010;
    else begin
      gated   = mWaiting || (mFirst && !inRunMode);
      granted = !gated || (inStepReq && !mPrevReq);
      haz = inMemReadEx && (inRtEx != 0) && (inRtEx == inRsId || inRtEx == inRtId);
      if (granted) begin
        if (inHaltId) goHalt = 1;
        else if (haz) begin ctl = 7'b0000010; stallEv = 1; end
        else if (inJumpId) begin ctl = 7'b1010110; redirect = 1; end
        else if (inBranchTaken) begin ctl = 7'b1011010; redirect = 1; end
        else ctl = 7'b1100010;
      end
    end
  endtask

  task automatic checkOutput(input string name, input bit useExp, input logic [6:0] expCtl);
    logic [6:0] ctl, act;
    bit stallEv, goHalt, redirect;
    int expS, expF;
    modelEval(ctl, stallEv, goHalt, redirect);
    act = {outPCWrite, outIF_IDWrite, outIF_Flush, outPCSrc, outJump, outEnable, outHalted};
`ifdef FETCH_PERF_CNT_EN
    expS = mStall; expF = mFlush;
`else
    expS = 0; expF = 0;
`endif
    compare({name, "/ctl"}, int'(act), int'(useExp ? expCtl : ctl));
    compare({name, "/stallCnt"}, int'(outStallCnt), expS);
    compare({name, "/flushCnt"}, int'(outFlushCnt), expF);
    if (reset) begin
      if (ctl[4]) mFlush = (mFlush < CNT_MAX) ? mFlush + 1 : CNT_MAX;
      if (stallEv) mStall = (mStall < CNT_MAX) ? mStall + 1 : CNT_MAX;
      if (!mHalted) begin
        if (goHalt) mHalted = 1;
        else if (mFlushLeft > 0) mFlushLeft--;
        else if (redirect) mFlushLeft = FC - 1;
        mWaiting = !inRunMode;
      end
      mFirst = 0;
      mPrevReq = inStepReq;
    end
  endtask

  task automatic doReset(input logic rm);
    @(negedge clk);
    #2;
    reset = 1'b0;
    inMemReadEx = 0; inBranchTaken = 0; inJumpId = 0; inHaltId = 0; inStepReq = 0;
    #1;
    compare("reset/ctl", int'({outPCWrite, outIF_IDWrite, outIF_Flush, outPCSrc, outJump,
                               outEnable, outHalted}), int'(7'b0010000));
    compare("reset/stallCnt", int'(outStallCnt), 0);
    compare("reset/flushCnt", int'(outFlushCnt), 0);
    mHalted = 0; mFlushLeft = 0; mWaiting = 0; mFirst = 1; mPrevReq = 0; mStall = 0; mFlush = 0;
    @(posedge clk);
    #2;
    inRunMode = rm;
    reset = 1'b1;
  endtask

  initial begin
    int pwCount;
    vecs[0]  = mkVec(0, 0, 0, 0, 0, 0, 0, 7'b1100010);
    vecs[1]  = mkVec(1, 5, 5, 0, 0, 0, 0, 7'b0000010);
    vecs[2]  = mkVec(1, 0, 0, 0, 0, 0, 0, 7'b1100010);
    vecs[3]  = mkVec(1, 7, 1, 7, 0, 0, 0, 7'b0000010);
    vecs[4]  = mkVec(0, 0, 0, 0, 1, 0, 0, 7'b1011010);
    vecs[5]  = mkVec(0, 0, 0, 0, 0, 0, 0, 7'b1010010);
    vecs[6]  = mkVec(1, 3, 3, 0, 1, 0, 0, 7'b1010010);
    vecs[7]  = mkVec(0, 0, 0, 0, 0, 0, 0, 7'b1100010);
    vecs[8]  = mkVec(0, 0, 0, 0, 1, 1, 0, 7'b1010110);
    vecs[9]  = mkVec(0, 0, 0, 0, 0, 1, 0, 7'b1010010);
    vecs[10] = mkVec(0, 0, 0, 0, 0, 0, 0, 7'b1010010);
    vecs[11] = mkVec(0, 0, 0, 0, 0, 0, 0, 7'b1100010);

    doReset(1'b1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].memRead, vecs[i].rtEx, vecs[i].rsId, vecs[i].rtId, vecs[i].branch,
                    vecs[i].jump, vecs[i].halt, vecs[i].runMode, vecs[i].stepReq);
      checkOutput($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
    end

    // Single-step: a held request grants one cycle, a fresh edge grants another.
    doReset(1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stepIdle", 1'b1, 7'b0000000);
    pwCount = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, (i < 5 || i == 7) ? 1'b1 : 1'b0);
      pwCount += int'(outPCWrite);
      checkOutput($sformatf("stepHold%0d", i), 1'b0, '0);
    end
    compare("stepGrants", pwCount, 2);

    // A stepped redirect finishes its bubbles before waiting again.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stepLow", 1'b0, '0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
    checkOutput("stepBranch", 1'b1, 7'b1011010);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput($sformatf("stepFlush%0d", i), 1'b1, (i < 2) ? 7'b1010010 : 7'b0000000);
    end

    // Reset in the middle of a flush returns straight to normal fetch.
    doReset(1'b1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0);
    checkOutput("midJump", 1'b0, '0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("midFlush", 1'b0, '0);
    doReset(1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("afterMidReset", 1'b1, 7'b1100010);

    // Halt is sticky against steps, redirects and mode changes.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("haltEnter", 1'b1, 7'b0000000);
    pwCount = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0, logic'(i % 2), logic'(i % 2));
      pwCount += int'(outPCWrite);
      checkOutput($sformatf("halted%0d", i), 1'b1, 7'b0000001);
    end
    compare("haltPcWrites", pwCount, 0);
    doReset(1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("haltExit", 1'b1, 7'b1100010);

    // Stall counter saturation.
    doReset(1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 9, 9, 2, 0, 0, 0, 1, 0);
      checkOutput($sformatf("sat%0d", i), 1'b0, '0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
`ifdef FETCH_PERF_CNT_EN
    compare("stallSaturated", int'(outStallCnt), CNT_MAX);
`else
    compare("stallTiedZero", int'(outStallCnt), 0);
`endif
    checkOutput("satTail", 1'b0, '0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 0) doReset(logic'($urandom_range(0, 3) != 0));
      applyStimulus(logic'($urandom % 2), 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
                    logic'($urandom % 5 == 0), logic'($urandom % 7 == 0),
                    logic'($urandom % 60 == 0), logic'($urandom % 10 != 0),
                    logic'($urandom % 2));
      checkOutput($sformatf("rand%0d", i), 1'b0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
